// File: rtl/dcpu_bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit dcpu-style slave port between NM masters.
// Optional BUSY timeout with forced completion is enabled by defining DCPU_ARB_TIMEOUT_EN.
module dcpu_bus_arbiter #(
   parameter int NM      = 2,
   parameter int TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [NM-1:0]    i_m_cs,
   input  logic [NM-1:0]    i_m_we,
   input  logic [NM*16-1:0] i_m_addr,
   input  logic [NM*16-1:0] i_m_dat,
   output logic [NM-1:0]    o_m_ack,
   output logic [15:0]      o_m_dat,
   output logic             o_s_cs,
   output logic             o_s_we,
   output logic [15:0]      o_s_addr,
   output logic [15:0]      o_s_dat,
   input  logic             i_s_ack,
   input  logic [15:0]      i_s_dat,
   output logic [NM-1:0]    o_grant,
   output logic             o_busy,
   output logic             o_err
);

   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   if (NM < 2 || NM > 8 || TIMEOUT < 1 || CW > 16) begin : g_bad_cfg
      $error("dcpu_bus_arbiter: NM must be 2..8 and TIMEOUT must be positive");
   end

   logic [0:0]    state_r;
   logic [NM-1:0] grant_r;
   logic [IW-1:0] last_r;
   logic [IW-1:0] gidx_s;
   logic [NM-1:0] pick_s;
   logic          any_req_s;
   logic          cs_g_s;
   logic          we_g_s;
   logic [15:0]   addr_g_s;
   logic [15:0]   dat_g_s;
   logic          tmo_s;
   logic          busy_s;

   function automatic logic [IW-1:0] onehot_to_idx(input logic [NM-1:0] oh);
      logic [IW-1:0] idx;
      idx = {IW{1'b0}};
      for (int i = 0; i < NM; i++) begin
         idx = idx | (oh[i] ? IW'(i) : {IW{1'b0}});
      end
      return idx;
   endfunction

   // First requester strictly after the last served master, wrapping modulo NM.
   function automatic logic [NM-1:0] rr_pick(input logic [NM-1:0] req, input logic [IW-1:0] last);
      logic [NM-1:0] pick;
      logic          found;
      logic [IW-1:0] idx;
      pick  = {NM{1'b0}};
      found = 1'b0;
      for (int i = 1; i <= NM; i++) begin
         idx = IW'((int'(last) + i) % NM);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end else begin
            pick  = pick;
            found = found;
         end
      end
      return pick;
   endfunction

   assign busy_s    = (state_r == S_BUSY);
   assign any_req_s = |i_m_cs;
   assign pick_s    = rr_pick(i_m_cs, last_r);
   assign gidx_s    = onehot_to_idx(grant_r);
   assign cs_g_s    = |(i_m_cs & grant_r);
   assign we_g_s    = |(i_m_we & grant_r);

   // Address/data mux from the one-hot grant.
   always_comb begin
      addr_g_s = 16'h0000;
      dat_g_s  = 16'h0000;
      for (int i = 0; i < NM; i++) begin
         addr_g_s = addr_g_s | (i_m_addr[16*i +: 16] & {16{grant_r[i]}});
         dat_g_s  = dat_g_s  | (i_m_dat[16*i +: 16]  & {16{grant_r[i]}});
      end
   end

`ifdef DCPU_ARB_TIMEOUT_EN
   logic [CW-1:0] tmo_cnt_r;

   // Timeout counter: held at zero in IDLE so every BUSY entry starts from 0.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else if (!busy_s) begin
         tmo_cnt_r <= {CW{1'b0}};
      end else if (!i_s_ack) begin
         tmo_cnt_r <= tmo_cnt_r + CW'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // A master that has already dropped cs is aborting, not timing out.
   assign tmo_s = busy_s && cs_g_s && !i_s_ack && (tmo_cnt_r == CW'(TIMEOUT));
`else
   assign tmo_s = 1'b0;
`endif

   // Slave-side mux and zero-latency ack path back to the granted master.
   always_comb begin
      o_s_cs   = 1'b0;
      o_s_we   = 1'b0;
      o_s_addr = 16'h0000;
      o_s_dat  = 16'h0000;
      o_m_ack  = {NM{1'b0}};
      if (busy_s) begin
         o_s_cs   = cs_g_s & ~tmo_s;
         o_s_we   = we_g_s;
         o_s_addr = addr_g_s;
         o_s_dat  = dat_g_s;
         o_m_ack  = grant_r & {NM{i_s_ack | tmo_s}};
      end else begin
         o_s_cs   = 1'b0;
         o_s_we   = 1'b0;
         o_s_addr = 16'h0000;
         o_s_dat  = 16'h0000;
         o_m_ack  = {NM{1'b0}};
      end
   end

   assign o_m_dat = tmo_s ? 16'hDEAD : i_s_dat;
   assign o_err   = tmo_s;
   assign o_busy  = busy_s;
   assign o_grant = grant_r;

   // Arbitration state, grant and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= S_IDLE;
         grant_r <= {NM{1'b0}};
         last_r  <= IW'(NM - 1);
      end else begin
         case (state_r)
            S_IDLE: begin
               if (any_req_s) begin
                  state_r <= S_BUSY;
                  grant_r <= pick_s;
               end else begin
                  state_r <= S_IDLE;
                  grant_r <= {NM{1'b0}};
               end
               last_r <= last_r;
            end
            S_BUSY: begin
               if (i_s_ack || tmo_s) begin
                  state_r <= S_IDLE;
                  grant_r <= {NM{1'b0}};
                  last_r  <= gidx_s;
               end else if (!cs_g_s) begin
                  state_r <= S_IDLE;
                  grant_r <= {NM{1'b0}};
                  last_r  <= last_r;
               end else begin
                  state_r <= S_BUSY;
                  grant_r <= grant_r;
                  last_r  <= last_r;
               end
            end
            default: begin
               state_r <= S_IDLE;
               grant_r <= {NM{1'b0}};
               last_r  <= last_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Table-driven bench for dcpu_bus_arbiter (NM=2) plus hand-written BUSY hold / timeout sequences.
module tb_dcpu_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  m_cs, m_we;
   logic [31:0] m_addr, m_dat;
   logic [1:0]  m_ack;
   logic [15:0] m_dat_o;
   logic        s_cs, s_we;
   logic [15:0] s_addr, s_dat_o;
   logic        s_ack;
   logic [15:0] s_dat;
   logic [1:0]  grant;
   logic        busy, err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dcpu_bus_arbiter #(.NM(2), .TIMEOUT(15)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_m_cs(m_cs), .i_m_we(m_we), .i_m_addr(m_addr), .i_m_dat(m_dat),
      .o_m_ack(m_ack), .o_m_dat(m_dat_o),
      .o_s_cs(s_cs), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_dat(s_dat_o),
      .i_s_ack(s_ack), .i_s_dat(s_dat),
      .o_grant(grant), .o_busy(busy), .o_err(err)
   );

   typedef struct packed {
      logic        rst;
      logic [1:0]  cs, we;
      logic [15:0] a0, a1, d0, d1;
      logic        sack;
      logic [15:0] sdat;
      logic [1:0]  e_ack;
      logic [15:0] e_mdat;
      logic        e_scs, e_swe;
      logic [15:0] e_saddr, e_sdat;
      logic [1:0]  e_grant;
      logic        e_busy;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic rst, input logic [1:0] cs, input logic [1:0] we,
      input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] d0, input logic [15:0] d1,
      input logic sack, input logic [15:0] sdat,
      input logic [1:0] e_ack, input logic [15:0] e_mdat, input logic e_scs, input logic e_swe,
      input logic [15:0] e_saddr, input logic [15:0] e_sdat, input logic [1:0] e_grant, input logic e_busy);
      vec_t v;
      v = {rst, cs, we, a0, a1, d0, d1, sack, sdat, e_ack, e_mdat, e_scs, e_swe, e_saddr, e_sdat, e_grant, e_busy};
      return v;
   endfunction

   task automatic drive(input logic rst, input logic [1:0] cs, input logic [1:0] we,
                        input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] d0,
                        input logic [15:0] d1, input logic sack, input logic [15:0] sdat);
      reset = rst; m_cs = cs; m_we = we;
      m_addr = {a1, a0}; m_dat = {d1, d0};
      s_ack = sack; s_dat = sdat;
   endtask

   task automatic check1(input string name, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic check_vec(input int k, input vec_t v);
      n_cmp++;
      if (m_ack !== v.e_ack || m_dat_o !== v.e_mdat || s_cs !== v.e_scs || s_we !== v.e_swe ||
          s_addr !== v.e_saddr || s_dat_o !== v.e_sdat || grant !== v.e_grant ||
          busy !== v.e_busy || err !== 1'b0) begin
         n_bad++;
         $display("FAIL vec%0d: got ack=%b mdat=%h scs=%b swe=%b saddr=%h sdat=%h grant=%b busy=%b err=%b; want ack=%b mdat=%h scs=%b swe=%b saddr=%h sdat=%h grant=%b busy=%b err=0",
                  k, m_ack, m_dat_o, s_cs, s_we, s_addr, s_dat_o, grant, busy, err,
                  v.e_ack, v.e_mdat, v.e_scs, v.e_swe, v.e_saddr, v.e_sdat, v.e_grant, v.e_busy);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          rst cs     we     a0        a1        d0       d1       ack  sdat     | ack    mdat     scs  swe  saddr     sdat     grant  busy
      // reset state, then a single read by master0 acked on the third BUSY cycle
      vq.push_back(mk(1'b0,2'b00,2'b00,16'h0000,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b01,2'b00,16'h0010,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b01,2'b00,16'h0010,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b1,1'b0,16'h0010,16'h0000,2'b01,1'b1));
      vq.push_back(mk(1'b0,2'b01,2'b00,16'h0010,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b1,1'b0,16'h0010,16'h0000,2'b01,1'b1));
      vq.push_back(mk(1'b0,2'b01,2'b00,16'h0010,16'h0000,16'h0000,16'h0000,1'b1,16'h1234, 2'b01,16'h1234,1'b1,1'b0,16'h0010,16'h0000,2'b01,1'b1));
      // reset, then contention: master0 first, then master1, then rotation
      vq.push_back(mk(1'b1,2'b00,2'b00,16'h0000,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b1,16'hAAAA, 2'b01,16'hAAAA,1'b1,1'b0,16'h0100,16'h0000,2'b01,1'b1));
      vq.push_back(mk(1'b0,2'b10,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b10,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b1,16'h5555, 2'b10,16'h5555,1'b1,1'b0,16'h0101,16'h0000,2'b10,1'b1));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b1,16'h0001, 2'b01,16'h0001,1'b1,1'b0,16'h0100,16'h0000,2'b01,1'b1));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0100,16'h0101,16'h0000,16'h0000,1'b1,16'h0002, 2'b10,16'h0002,1'b1,1'b0,16'h0101,16'h0000,2'b10,1'b1));
      vq.push_back(mk(1'b0,2'b00,2'b00,16'h0000,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      // write routing: master1 writes BEEF to 0200 while master0 waits for a read
      vq.push_back(mk(1'b0,2'b10,2'b10,16'h0000,16'h0200,16'h0000,16'hBEEF,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b11,2'b10,16'h0030,16'h0200,16'h0000,16'hBEEF,1'b0,16'h0000, 2'b00,16'h0000,1'b1,1'b1,16'h0200,16'hBEEF,2'b10,1'b1));
      vq.push_back(mk(1'b0,2'b11,2'b10,16'h0030,16'h0200,16'h0000,16'hBEEF,1'b1,16'h0000, 2'b10,16'h0000,1'b1,1'b1,16'h0200,16'hBEEF,2'b10,1'b1));
      vq.push_back(mk(1'b0,2'b01,2'b00,16'h0030,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b01,2'b00,16'h0030,16'h0000,16'h0000,16'h0000,1'b1,16'h7777, 2'b01,16'h7777,1'b1,1'b0,16'h0030,16'h0000,2'b01,1'b1));
      // abort by master1 (pointer must stay at 0), then spurious ack in IDLE
      vq.push_back(mk(1'b0,2'b10,2'b00,16'h0000,16'h0050,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b10,2'b00,16'h0000,16'h0050,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b1,1'b0,16'h0050,16'h0000,2'b10,1'b1));
      vq.push_back(mk(1'b0,2'b00,2'b00,16'h0000,16'h0050,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0050,16'h0000,2'b10,1'b1));
      vq.push_back(mk(1'b0,2'b00,2'b00,16'h0000,16'h0000,16'h0000,16'h0000,1'b1,16'h1111, 2'b00,16'h1111,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0060,16'h0050,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b11,2'b00,16'h0060,16'h0050,16'h0000,16'h0000,1'b1,16'h2222, 2'b10,16'h2222,1'b1,1'b0,16'h0050,16'h0000,2'b10,1'b1));
      // reset mid-transfer, then a master1-only request
      vq.push_back(mk(1'b0,2'b01,2'b00,16'h0070,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b1,2'b01,2'b00,16'h0070,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b1,1'b0,16'h0070,16'h0000,2'b01,1'b1));
      vq.push_back(mk(1'b0,2'b10,2'b00,16'h0000,16'h0080,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));
      vq.push_back(mk(1'b0,2'b10,2'b00,16'h0000,16'h0080,16'h0000,16'h0000,1'b1,16'h3333, 2'b10,16'h3333,1'b1,1'b0,16'h0080,16'h0000,2'b10,1'b1));
      vq.push_back(mk(1'b0,2'b00,2'b00,16'h0000,16'h0000,16'h0000,16'h0000,1'b0,16'h0000, 2'b00,16'h0000,1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0));

      drive(1'b1, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      step();
      step();

      for (int k = 0; k < vq.size(); k++) begin
         drive(vq[k].rst, vq[k].cs, vq[k].we, vq[k].a0, vq[k].a1, vq[k].d0, vq[k].d1, vq[k].sack, vq[k].sdat);
         @(negedge clk);
         check_vec(k, vq[k]);
         step();
      end

`ifdef DCPU_ARB_TIMEOUT_EN
      // Slave never acks: forced completion on BUSY cycle TIMEOUT (counted from 0).
      drive(1'b0, 2'b01, 2'b00, 16'h0090, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      step();
      for (int b = 0; b <= 15; b++) begin
         @(negedge clk);
         if (b < 15) begin
            check1("tmo_wait_ack", {14'h0, m_ack}, 16'h0000);
            check1("tmo_wait_err", {15'h0, err}, 16'h0000);
         end else begin
            check1("tmo_ack", {14'h0, m_ack}, 16'h0001);
            check1("tmo_mdat", m_dat_o, 16'hDEAD);
            check1("tmo_err", {15'h0, err}, 16'h0001);
            check1("tmo_scs", {15'h0, s_cs}, 16'h0000);
         end
         step();
      end
      drive(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      @(negedge clk);
      check1("tmo_idle_busy", {15'h0, busy}, 16'h0000);
      check1("tmo_idle_err", {15'h0, err}, 16'h0000);
      step();
      // Real ack on the timeout cycle wins.
      drive(1'b0, 2'b01, 2'b00, 16'h0091, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      step();
      for (int b = 0; b <= 15; b++) begin
         if (b == 15) begin
            s_ack = 1'b1;
            s_dat = 16'h4444;
         end else begin
            s_ack = 1'b0;
         end
         @(negedge clk);
         if (b == 15) begin
            check1("race_ack", {14'h0, m_ack}, 16'h0001);
            check1("race_mdat", m_dat_o, 16'h4444);
            check1("race_err", {15'h0, err}, 16'h0000);
            check1("race_scs", {15'h0, s_cs}, 16'h0001);
         end else begin
            check1("race_wait_ack", {14'h0, m_ack}, 16'h0000);
         end
         step();
      end
`else
      // Without the timeout, BUSY holds indefinitely and o_err stays low.
      drive(1'b0, 2'b01, 2'b00, 16'h0090, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      step();
      for (int b = 0; b < 20; b++) begin
         @(negedge clk);
         if (b == 0 || b == 15 || b == 19) begin
            check1("hold_busy", {15'h0, busy}, 16'h0001);
            check1("hold_ack", {14'h0, m_ack}, 16'h0000);
            check1("hold_err", {15'h0, err}, 16'h0000);
            check1("hold_mdat", m_dat_o, 16'h0000);
         end
         step();
      end
      drive(1'b0, 2'b01, 2'b00, 16'h0090, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h6666);
      @(negedge clk);
      check1("hold_late_ack", {14'h0, m_ack}, 16'h0001);
      check1("hold_late_mdat", m_dat_o, 16'h6666);
      step();
`endif
      drive(1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      @(negedge clk);
      check1("final_busy", {15'h0, busy}, 16'h0000);
      check1("final_grant", {14'h0, grant}, 16'h0000);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
